// File: rtl/display_pkg.sv
// Shared types and segment constants for the BCD display scanner.
package display_pkg;

   localparam int unsigned BCD_W   = 16;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned DIGIT_N = 4;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_REQ  = 2'd1,
      S_CAPT = 2'd2,
      S_REL  = 2'd3
   } state_t;

   // Active-high patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Conversion handshake between the scanner (master) and the binary-to-BCD converter (slave).
interface bcd_display_scanner_if;
   import display_pkg::*;

   logic             conv_start;
   logic             conv_ready;
   logic [BCD_W-1:0] conv_bcd;

   modport master (output conv_start, input conv_ready, input conv_bcd);
   modport slave  (input conv_start, output conv_ready, output conv_bcd);

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment pattern; non-decimal nibbles show a dash.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   input  logic             blank,
   output logic [SEG_W-1:0] seg_c
);

   // Blanking overrides the decode
   always_comb begin
      seg_c = SEG_DASH;
      if (blank) begin
         seg_c = SEG_BLANK;
      end else begin
         case (nibble)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Requests periodic BCD conversions, captures the result and scans it onto a 4-digit display.
module bcd_display_scanner
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned SAMPLE_DIV  = 10000000,
   parameter int unsigned TIMEOUT     = 64,
   parameter bit          ACTIVE_LOW  = 1'b1,
   parameter bit          BLANK_LZ    = 1'b1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   bcd_display_scanner_if.master conv,
   output logic [SEG_W-1:0]     seg,
   output logic                 dp,
   output logic [DIGIT_N-1:0]   an,
   output logic [BCD_W-1:0]     disp_value,
   output logic                 update_pulse,
   output logic                 conv_err
);

   localparam int unsigned SAMPLE_W  = (SAMPLE_DIV  > 1) ? $clog2(SAMPLE_DIV)  : 1;
   localparam int unsigned REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned TMO_W     = (TIMEOUT     > 1) ? $clog2(TIMEOUT)     : 1;
   localparam int unsigned IDX_W     = 2;

   localparam logic [SAMPLE_W-1:0]  SAMPLE_LAST  = SAMPLE_W'(SAMPLE_DIV - 1);
   localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
   localparam logic [TMO_W-1:0]     TMO_LAST     = TMO_W'(TIMEOUT - 1);

   // Polarity masks: XOR with these turns an active-high value into the pin level
   localparam logic [SEG_W-1:0]   SEG_OFF = {SEG_W{ACTIVE_LOW}};
   localparam logic [DIGIT_N-1:0] AN_OFF  = {DIGIT_N{ACTIVE_LOW}};

   state_t               state, state_d;
   logic [SAMPLE_W-1:0]  sample_cnt;
   logic [REFRESH_W-1:0] refresh_cnt;
   logic [TMO_W-1:0]     tmo_cnt, tmo_d;
   logic [IDX_W-1:0]     digit_idx;
   logic                 start_q, start_d;
   logic [BCD_W-1:0]     disp_d;
   logic                 pulse_d;
   logic                 err_d;
   logic                 tick;
   logic [NIB_W-1:0]     nibble;
   logic [BCD_W-1:0]     upper;
   logic                 blank;
   logic [SEG_W-1:0]     pattern_c;
   logic [DIGIT_N-1:0]   onehot;

   assign tick            = (sample_cnt == SAMPLE_LAST);
   assign conv.conv_start = start_q;

   // Free-running sample divider
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_cnt <= '0;
      end else if (tick) begin
         sample_cnt <= '0;
      end else begin
         sample_cnt <= sample_cnt + SAMPLE_W'(1);
      end
   end

   // Handshake FSM state and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_WAIT;
         tmo_cnt      <= '0;
         start_q      <= 1'b0;
         disp_value   <= '0;
         update_pulse <= 1'b0;
         conv_err     <= 1'b0;
      end else begin
         state        <= state_d;
         tmo_cnt      <= tmo_d;
         start_q      <= start_d;
         disp_value   <= disp_d;
         update_pulse <= pulse_d;
         conv_err     <= err_d;
      end
   end

   // Next state; capture waits one cycle after ready so the converter's bcd register has settled
   always_comb begin
      state_d = state;
      tmo_d   = tmo_cnt;
      disp_d  = disp_value;
      pulse_d = 1'b0;
      err_d   = conv_err;
      case (state)
         S_WAIT: begin
            tmo_d = '0;
            if (tick && enable) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (conv.conv_ready) begin
               state_d = S_CAPT;
            end else if (tmo_cnt == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_REL;
            end else begin
               tmo_d = tmo_cnt + TMO_W'(1);
            end
         end
         S_CAPT: begin
            disp_d  = conv.conv_bcd;
            pulse_d = 1'b1;
            err_d   = 1'b0;
            state_d = S_REL;
         end
         S_REL: begin
            if (!conv.conv_ready) begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_WAIT;
      endcase
      start_d = (state_d == S_REQ) || (state_d == S_CAPT);
   end

   // Digit refresh divider and scan index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (refresh_cnt == REFRESH_LAST) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_idx + IDX_W'(1);
      end else begin
         refresh_cnt <= refresh_cnt + REFRESH_W'(1);
      end
   end

   // Active nibble and leading-zero blanking (digit blank when it and all higher nibbles are zero)
   always_comb begin
      nibble = disp_value[{digit_idx, 2'b00} +: NIB_W];
      upper  = disp_value >> {digit_idx, 2'b00};
      blank  = BLANK_LZ && (digit_idx != '0) && (upper == '0);
      onehot = DIGIT_N'(1) << digit_idx;
   end

   bcd_to_7seg u_dec (
      .nibble (nibble),
      .blank  (blank),
      .seg_c  (pattern_c)
   );

   // Segments and anodes update on the same edge to avoid ghosting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
         dp  <= ACTIVE_LOW;
      end else begin
         seg <= pattern_c ^ SEG_OFF;
         an  <= onehot ^ AN_OFF;
         dp  <= ACTIVE_LOW;
      end
   end

endmodule
